// File: rtl/mod_dec_inv_mix_columns.sv
// AES decryption InvMixColumns stage: iterative, one column per clock,
// full 128-bit result published with a single-cycle done pulse.
module mod_dec_inv_mix_columns #(
    parameter int N = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [N-1:0][7:0] state,
    output logic [N-1:0][7:0] state_out,
    output logic              busy,
    output logic              done
);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic              fsm;
    logic [1:0]        col;
    logic [N-1:0][7:0] in_buf;
    logic [N-1:0][7:0] res_buf;
    logic [N-1:0][7:0] res_next;

    logic [7:0] r0, r1, r2, r3;
    logic [7:0] o0, o1, o2, o3;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Row 0 of a column sits in its highest-addressed byte.
    always_comb begin
        r0 = in_buf[{col, 2'd3}];
        r1 = in_buf[{col, 2'd2}];
        r2 = in_buf[{col, 2'd1}];
        r3 = in_buf[{col, 2'd0}];
    end

    always_comb begin
        o0 = mule(r0) ^ mulb(r1) ^ muld(r2) ^ mul9(r3);
        o1 = mul9(r0) ^ mule(r1) ^ mulb(r2) ^ muld(r3);
        o2 = muld(r0) ^ mul9(r1) ^ mule(r2) ^ mulb(r3);
        o3 = mulb(r0) ^ muld(r1) ^ mul9(r2) ^ mule(r3);
    end

    always_comb begin
        res_next = res_buf;
        res_next[{col, 2'd3}] = o0;
        res_next[{col, 2'd2}] = o1;
        res_next[{col, 2'd1}] = o2;
        res_next[{col, 2'd0}] = o3;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm       <= IDLE;
            col       <= 2'd0;
            in_buf    <= '0;
            res_buf   <= '0;
            state_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (enable) begin
                        in_buf <= state;
                        col    <= 2'd0;
                        fsm    <= RUN;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    res_buf <= res_next;
                    if (col == 2'd3) begin
                        // Publish only complete results.
                        state_out <= res_next;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        col       <= 2'd0;
                        fsm       <= IDLE;
                    end else begin
                        col <= col + 2'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_dec_inv_mix_columns.sv
// Bench for mod_dec_inv_mix_columns: GF(2^8) matrix model, per-cycle
// compare of done/busy/state_out, directed vectors and round trips.
module tb_mod_dec_inv_mix_columns;

    logic         clk;
    logic         reset;
    logic         enable;
    logic [127:0] state_in;
    logic [127:0] state_out;
    logic         busy;
    logic         done;

    int n_pass;
    int n_total;
    bit stop_cmp;

    bit           m_busy;
    bit           m_done;
    int           m_left;
    logic [127:0] m_out;
    logic [127:0] m_pend;

    mod_dec_inv_mix_columns #(.N(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .state     (state_in),
        .state_out (state_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [8:0] t;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            t = {a, 1'b0};
            if (t[8]) t = t ^ 9'h11b;
            a = t[7:0];
        end
        return p;
    endfunction

    // Column word is {row0,row1,row2,row3}; base is the first matrix row.
    function automatic logic [31:0] col_mat(input logic [31:0] c, input logic [31:0] base);
        logic [7:0] r [4];
        logic [7:0] k [4];
        logic [7:0] o [4];
        for (int i = 0; i < 4; i++) begin
            r[i] = c[31-8*i -: 8];
            k[i] = base[31-8*i -: 8];
        end
        for (int row = 0; row < 4; row++) begin
            o[row] = 8'h00;
            for (int j = 0; j < 4; j++)
                o[row] = o[row] ^ gf_mul(k[(j - row + 4) % 4], r[j]);
        end
        return {o[0], o[1], o[2], o[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            r[32*c +: 32] = col_mat(s[32*c +: 32], 32'h0e0b0d09);
        return r;
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            r[32*c +: 32] = col_mat(s[32*c +: 32], 32'h02030101);
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: accepted block completes four edges after acceptance.
    initial begin
        m_busy = 0; m_done = 0; m_left = 0; m_out = '0; m_pend = '0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_busy = 0; m_done = 0; m_left = 0; m_out = '0;
            end else begin
                m_done = 0;
                if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_out  = m_pend;
                        m_done = 1;
                        m_busy = 0;
                    end
                end else if (enable) begin
                    m_pend = inv_mix(state_in);
                    m_busy = 1;
                    m_left = 4;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!stop_cmp) begin
                check("cyc_done", {127'd0, done}, {127'd0, m_done});
                check("cyc_busy", {127'd0, busy}, {127'd0, m_busy});
                check("cyc_out", state_out, m_out);
            end
        end
    end

    task automatic run_block(input logic [127:0] s, output logic [127:0] r, output int lat);
        @(posedge clk); #2;
        state_in = s;
        enable   = 1'b1;
        @(posedge clk); #2;
        enable = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i - 1;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 128'd0, 128'd1);
        r = state_out;
    endtask

    logic [127:0] res;
    logic [127:0] saved;
    logic [127:0] orig;
    int           lat;
    int           cnt;

    initial begin
        n_pass = 0; n_total = 0; stop_cmp = 0;
        reset = 1'b1; enable = 1'b0; state_in = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", state_out, 128'd0);
        check("reset_flags", {126'd0, busy, done}, 128'd0);
        #3 reset = 1'b1;

        check("pin_col_a", {96'd0, col_mat(32'h8e4da1bc, 32'h0e0b0d09)}, {96'd0, 32'hdb135345});
        check("pin_col_b", {96'd0, col_mat(32'hdb135345, 32'h02030101)}, {96'd0, 32'h8e4da1bc});

        run_block({4{32'h8e4da1bc}}, res, lat);
        check("vec_a", res, {4{32'hdb135345}});
        check("lat_a", 128'(lat), 128'd4);
        run_block({4{32'h9fdc589d}}, res, lat);
        check("vec_b", res, {4{32'hf20a225c}});
        check("lat_b", 128'(lat), 128'd4);
        run_block({4{32'h4d7ebdf8}}, res, lat);
        check("vec_c", res, {4{32'h2d26314c}});
        run_block(128'h8e4da1bc_c6c6c6c6_01010101_d5d5d7d6, res, lat);
        check("vec_mixed", res, 128'hdb135345_c6c6c6c6_01010101_d4d4d4d5);

        // Hold after completion.
        saved = state_out;
        repeat (10) @(negedge clk);
        check("hold_out", state_out, saved);
        check("hold_flags", {126'd0, busy, done}, 128'd0);

        // Enable held high while the input keeps changing.
        @(posedge clk); #2;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        enable = 1'b1;
        @(posedge clk);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) cnt++;
            state_in = {$urandom, $urandom, $urandom, $urandom};
        end
        enable = 1'b0;
        check("done_pulses", 128'(cnt), 128'd5);
        repeat (6) @(negedge clk);

        // Asynchronous reset mid-block with column 2 pending.
        @(posedge clk); #2;
        state_in = {4{32'h9fdc589d}};
        enable = 1'b1;
        @(posedge clk); #2;
        enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst_out", state_out, 128'd0);
        check("arst_flags", {126'd0, busy, done}, 128'd0);
        #2 reset = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("arst_no_done", 128'(cnt), 128'd0);

        for (int i = 0; i < 1000; i++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            run_block(fwd_mix(orig), res, lat);
            check("round_trip", res, orig);
        end

        repeat (2) @(negedge clk);
        stop_cmp = 1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
